// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the control unit and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [2:0]       funct;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, funct, op_a, op_b,
      input  busy, done, result
   );

   modport slave (
      input  start, funct, op_a, op_b,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit (RV64 M-extension operations).
// Fixed latency: WIDTH CALC cycles, one FIX cycle, one DONE cycle.
module muldiv_unit #(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic          clk,
   input logic          Reset,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         funct_q;
   logic               a_neg;      // latched sign of the (signed-view) rs1 operand
   logic               b_neg;      // latched sign of the (signed-view) rs2 operand
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   a_raw;      // unmodified op_a, needed by the special cases
   logic [WIDTH-1:0]   mcand;      // multiplicand magnitude, or divisor magnitude
   logic [2*WIDTH-1:0] prod;       // product; low half doubles as dividend/quotient shifter
   logic [WIDTH-1:0]   rem;        // partial remainder between iterations

   // Operand decode for the IDLE cycle
   logic             is_div;
   logic             a_signed;
   logic             b_signed;
   logic             in_a_neg;
   logic             in_b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // Decode signedness and form operand magnitudes from the live inputs
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
      is_div   = bus.funct[2];
      a_signed = (bus.funct == F_MULH) || (bus.funct == F_MULHSU) ||
                 (bus.funct == F_DIV)  || (bus.funct == F_REM);
      b_signed = (bus.funct == F_MULH) || (bus.funct == F_DIV) || (bus.funct == F_REM);
      in_a_neg = a_signed & bus.op_a[WIDTH-1];
      in_b_neg = b_signed & bus.op_b[WIDTH-1];
      a_mag    = in_a_neg ? -bus.op_a : bus.op_a;
      b_mag    = in_b_neg ? -bus.op_b : bus.op_b;
   end

   // One shift/add or shift/subtract step
   logic [WIDTH:0] mul_sum;
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] rem_diff;

   // Iteration arithmetic: carry-out add for multiply, W+1-bit trial subtract for divide
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      rem_shift = {rem, prod[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, mcand};
   end

   // Sign correction, special-case override and output select
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_signed;
   logic [WIDTH-1:0]   rem_signed;
   logic [WIDTH-1:0]   fix_result;

   // Final result formed from the magnitudes computed in CALC
   always_comb begin
      prod_signed = (a_neg ^ b_neg) ? -prod : prod;
      quo_signed  = (a_neg ^ b_neg) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      rem_signed  = a_neg ? -rem : rem;
      if (div_zero) begin
         quo_signed = '1;
         rem_signed = a_raw;
      end else if (div_ovf) begin
         quo_signed = a_raw;
         rem_signed = '0;
      end
      case (funct_q)
         F_MUL:                     fix_result = prod_signed[WIDTH-1:0];
         F_MULH, F_MULHSU, F_MULHU: fix_result = prod_signed[2*WIDTH-1:WIDTH];
         F_DIV, F_DIVU:             fix_result = quo_signed;
         default:                   fix_result = rem_signed;
      endcase
   end

   // Control FSM with registered busy/done/result and the iteration datapath
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         funct_q    <= '0;
         a_neg      <= 1'b0;
         b_neg      <= 1'b0;
         div_zero   <= 1'b0;
         div_ovf    <= 1'b0;
         a_raw      <= '0;
         mcand      <= '0;
         prod       <= '0;
         rem        <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  funct_q  <= bus.funct;
                  a_neg    <= in_a_neg;
                  b_neg    <= in_b_neg;
                  a_raw    <= bus.op_a;
                  div_zero <= is_div && (bus.op_b == '0);
                  div_ovf  <= is_div && a_signed && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
                  mcand    <= is_div ? b_mag : a_mag;
                  prod     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                  rem      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (funct_q[2]) begin
                  // Restoring divide: keep the difference only if it did not borrow
                  if (!rem_diff[WIDTH]) begin
                     rem              <= rem_diff[WIDTH-1:0];
                     prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b1};
                  end else begin
                     rem              <= rem_shift[WIDTH-1:0];
                     prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  prod <= {mul_sum, prod[WIDTH-1:1]};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) state <= FIX;
            end
            FIX: begin
               bus.result <= fix_result;
               bus.done   <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table at WIDTH=64 plus
// handshake, back-to-back, reset-abort and WIDTH=32 sequences.
module tb_muldiv_unit;

   localparam int MAX_WAIT = 200;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(64)) bus64 ();
   muldiv_unit_if #(.WIDTH(32)) bus32 ();

   muldiv_unit #(.WIDTH(64)) dut64 (.clk(clk), .Reset(rst), .bus(bus64));
   muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .Reset(rst), .bus(bus32));

   typedef struct {
      string       name;
      logic [2:0]  funct;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Issue one op on the 64-bit unit; lat = edges from accept to the edge that samples done
   task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
      int k;
      @(negedge clk);
      bus64.start = 1'b1;
      bus64.funct = f;
      bus64.op_a  = a;
      bus64.op_b  = b;
      @(negedge clk);
      bus64.start = 1'b0;
      k = 0;
      while (bus64.done !== 1'b1 && k < MAX_WAIT) begin
         @(negedge clk);
         k++;
      end
      res = bus64.result;
      lat = k + 1;
   endtask

   task automatic run32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      int k;
      @(negedge clk);
      bus32.start = 1'b1;
      bus32.funct = f;
      bus32.op_a  = a;
      bus32.op_b  = b;
      @(negedge clk);
      bus32.start = 1'b0;
      k = 0;
      while (bus32.done !== 1'b1 && k < MAX_WAIT) begin
         @(negedge clk);
         k++;
      end
      res = bus32.result;
      lat = k + 1;
   endtask

   initial begin
      logic [63:0] res;
      logic [63:0] r1;
      logic [63:0] r2;
      logic [31:0] res32;
      int          lat;
      int          k;
      int          first;
      int          second;
      int          dones;

      vecs.push_back('{"mul_7_m3",     3'b000, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
      vecs.push_back('{"mulh_min_2",   3'b001, 64'h8000_0000_0000_0000, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"mulhu_min_2",  3'b011, 64'h8000_0000_0000_0000, 64'd2,                  64'd1});
      vecs.push_back('{"mulhsu_m1_2",  3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"div_m7_2",     3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFD});
      vecs.push_back('{"rem_m7_2",     3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"divu_100_7",   3'b101, 64'd100,                 64'd7,                  64'd14});
      vecs.push_back('{"remu_100_7",   3'b111, 64'd100,                 64'd7,                  64'd2});
      vecs.push_back('{"div_5_0",      3'b100, 64'd5,                   64'd0,                  64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"rem_5_0",      3'b110, 64'd5,                   64'd0,                  64'd5});
      vecs.push_back('{"divu_5_0",     3'b101, 64'd5,                   64'd0,                  64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"remu_5_0",     3'b111, 64'd5,                   64'd0,                  64'd5});
      vecs.push_back('{"div_ovf",      3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
      vecs.push_back('{"rem_ovf",      3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
      vecs.push_back('{"div_7_m2",     3'b100, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD});
      vecs.push_back('{"rem_7_m2",     3'b110, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
      vecs.push_back('{"mul_big",      3'b000, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001});
      vecs.push_back('{"mulhu_big",    3'b011, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'd1});
      vecs.push_back('{"mulh_m1_m1",   3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
      vecs.push_back('{"mulhu_ones",   3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});

      // Reset both instances
      rst         = 1'b1;
      bus64.start = 1'b0; bus64.funct = '0; bus64.op_a = '0; bus64.op_b = '0;
      bus32.start = 1'b0; bus32.funct = '0; bus32.op_a = '0; bus32.op_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_busy64",   64'(bus64.busy),   64'd0);
      check("reset_done64",   64'(bus64.done),   64'd0);
      check("reset_result64", bus64.result,      64'd0);
      check("reset_busy32",   64'(bus32.busy),   64'd0);
      check("reset_result32", 64'(bus32.result), 64'd0);

      // Table-driven vectors: result and fixed latency of WIDTH+2 edges
      for (int i = 0; i < vecs.size(); i++) begin
         run64(vecs[i].funct, vecs[i].a, vecs[i].b, res, lat);
         check({vecs[i].name, "_result"}, res, vecs[i].exp);
         check({vecs[i].name, "_latency"}, 64'(lat), 64'd66);
      end

      // start pulsed mid-CALC with different operands must be ignored
      @(negedge clk);
      bus64.start = 1'b1; bus64.funct = 3'b101; bus64.op_a = 64'd100; bus64.op_b = 64'd7;
      @(negedge clk);
      check("busy_after_accept", 64'(bus64.busy), 64'd1);
      k = 0;
      while (bus64.done !== 1'b1 && k < MAX_WAIT) begin
         bus64.start = (k == 10);
         if (k == 10) begin
            bus64.funct = 3'b000; bus64.op_a = 64'd3; bus64.op_b = 64'd3;
         end
         @(negedge clk);
         k++;
      end
      bus64.start = 1'b0;
      check("midcalc_result",  bus64.result, 64'd14);
      check("midcalc_latency", 64'(k + 1),   64'd66);
      dones = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus64.done === 1'b1) dones++;
      end
      check("midcalc_no_extra_done", 64'(dones), 64'd0);
      check("midcalc_result_hold",   bus64.result, 64'd14);
      check("midcalc_busy_idle",     64'(bus64.busy), 64'd0);

      // start held high: back-to-back ops, operands resampled in each IDLE cycle
      @(negedge clk);
      bus64.start = 1'b1; bus64.funct = 3'b101; bus64.op_a = 64'd100; bus64.op_b = 64'd7;
      @(negedge clk);
      k = 0; first = -1; second = -1; r1 = '0; r2 = '0;
      while (second < 0 && k < 3 * MAX_WAIT) begin
         if (bus64.done === 1'b1) begin
            if (first < 0) begin
               first = k;
               r1 = bus64.result;
               bus64.op_a = 64'd200;
            end else begin
               second = k;
               r2 = bus64.result;
               bus64.start = 1'b0;
            end
         end
         if (second < 0) begin
            @(negedge clk);
            k++;
         end
      end
      bus64.start = 1'b0;
      check("b2b_first_latency", 64'(first + 1),     64'd66);
      check("b2b_first_result",  r1,                 64'd14);
      check("b2b_period",        64'(second - first), 64'd67);
      check("b2b_second_result", r2,                 64'd28);

      // Reset at CALC iteration 30 aborts the op with no done
      @(negedge clk);
      @(negedge clk);
      bus64.start = 1'b1; bus64.funct = 3'b000; bus64.op_a = 64'd7; bus64.op_b = 64'hFFFF_FFFF_FFFF_FFFD;
      @(negedge clk);
      bus64.start = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_busy_before", 64'(bus64.busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy",   64'(bus64.busy), 64'd0);
      check("abort_result", bus64.result,    64'd0);
      check("abort_done",   64'(bus64.done), 64'd0);
      rst = 1'b0;
      dones = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus64.done === 1'b1) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);

      // WIDTH=32 variant: latency WIDTH+2
      run32(3'b101, 32'hFFFF_FFFF, 32'h0000_0010, res32, lat);
      check("w32_divu_result",  64'(res32), 64'h0000_0000_0FFF_FFFF);
      check("w32_divu_latency", 64'(lat),   64'd34);
      run32(3'b110, 32'hFFFF_FFF9, 32'd2, res32, lat);
      check("w32_rem_result",   64'(res32), 64'h0000_0000_FFFF_FFFF);
      check("w32_rem_latency",  64'(lat),   64'd34);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
